// File: rtl/mips_single_cycle_core.sv
// mips_single_cycle_core
//   Single-cycle 32-bit MIPS core: PC, 32x32 register file, ALU, decode and
//   next-PC selection. Each instruction is fetched, executed and retired in
//   one clk period. Instruction and data memories are external and read
//   combinationally.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-low reset (PC <= RESET_PC, registers <= 0)
//   inst_adr   byte address of the current instruction (PC)
//   inst       instruction word for inst_adr
//   data_adr   data memory byte address (ALU result, always driven)
//   data_out   read data from data memory
//   data_in    write data to data memory (rt value, always driven)
//   mem_read   high while executing lw
//   mem_write  high while executing sw; memory writes on the rising edge
//
// Supported: add sub and or slt jr addi slti lw sw beq j jal.
// Any other encoding retires as a no-op that advances PC by 4.

module mips_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_adr,
  input  logic [31:0] inst,
  output logic [31:0] data_adr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_read,
  output logic        mem_write
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};

  // Decoded control
  logic    rf_we;
  logic    dst_rd;
  logic    dst_ra;
  logic    alu_imm;
  alu_op_e alu_op;
  logic    wb_mem;
  logic    wb_link;
  logic    is_beq;
  logic    is_jump;
  logic    is_jr;

  always_comb begin
    rf_we     = 1'b0;
    dst_rd    = 1'b0;
    dst_ra    = 1'b0;
    alu_imm   = 1'b0;
    alu_op    = ALU_ADD;
    wb_mem    = 1'b0;
    wb_link   = 1'b0;
    is_beq    = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin rf_we = 1'b1; dst_rd = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin rf_we = 1'b1; dst_rd = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin rf_we = 1'b1; dst_rd = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin rf_we = 1'b1; dst_rd = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin rf_we = 1'b1; dst_rd = 1'b1; alu_op = ALU_SLT; end
          FN_JR:  is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin rf_we = 1'b1; alu_imm = 1'b1; alu_op = ALU_ADD; end
      OP_SLTI: begin rf_we = 1'b1; alu_imm = 1'b1; alu_op = ALU_SLT; end
      OP_LW: begin
        rf_we    = 1'b1;
        alu_imm  = 1'b1;
        wb_mem   = 1'b1;
        mem_read = 1'b1;
      end
      OP_SW: begin
        alu_imm   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: is_beq = 1'b1;
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        rf_we   = 1'b1;
        dst_ra  = 1'b1;
        wb_link = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file: $0 is never written and always reads zero
  logic [31:0] rf_q [32];
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  // ALU
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  assign alu_b = alu_imm ? imm_sext : rt_val;

  always_comb begin
    alu_y = 32'd0;
    case (alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
  end

  // PC and next-PC selection
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (is_jr)
      pc_d = rs_val;
    else if (is_jump)
      pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
    else if (is_beq && (rs_val == rt_val))
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  // Write-back
  always_comb begin
    rf_waddr = rt;
    if (dst_ra)
      rf_waddr = 5'd31;
    else if (dst_rd)
      rf_waddr = rd;
  end

  always_comb begin
    rf_wdata = alu_y;
    if (wb_link)
      rf_wdata = pc_plus4;
    else if (wb_mem)
      rf_wdata = data_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign inst_adr = pc_q;
  assign data_adr = alu_y;
  assign data_in  = rt_val;

endmodule

// File: tb/tb_mips_single_cycle_core.sv
module tb_mips_single_cycle_core;

  logic        clk;
  logic        rst;
  logic [31:0] inst_adr;
  logic [31:0] inst;
  logic [31:0] data_adr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;

  mips_single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_adr  (inst_adr),
    .inst      (inst),
    .data_adr  (data_adr),
    .data_out  (data_out),
    .data_in   (data_in),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );

  // 16 ns period; first falling edge at 8 ns so the first fetch after the
  // 20 ns reset release is sampled at 24 ns.
  initial clk = 1'b1;
  always #8 clk = ~clk;

  // Instruction memory (64 words, unused words are sll $0 = no-op)
  logic [31:0] imem [64];
  assign inst = (inst_adr < 32'd256) ? imem[inst_adr[7:2]] : 32'd0;

  // Data memory
  logic [31:0] dmem [128];
  assign data_out = dmem[data_adr[8:2]];
  always @(posedge clk)
    if (mem_write) dmem[data_adr[8:2]] <= data_in;

  function automatic logic [31:0] enc_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                        input logic [4:0] rd_f, input logic [5:0] fn);
    return {6'b000000, rs_f, rt_f, rd_f, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] imm);
    return {opc, rs_f, rt_f, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [31:0] target);
    return {opc, target[27:2]};
  endfunction

  // Scoreboard
  typedef struct {
    logic        is_write;
    logic [31:0] adr;
    logic [31:0] data;
  } mem_ev_t;

  logic [31:0] pc_q[$];
  mem_ev_t     mem_q[$];
  int          n_checks;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_mem(input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_ev_t e;
    e.is_write = w;
    e.adr      = a;
    e.data     = d;
    mem_q.push_back(e);
  endtask

  // Hand-computed trace of the program loaded below
  task automatic push_expected();
    logic [31:0] pcs [29];
    pcs = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50,
            32'h54, 32'h58, 32'h0C, 32'h10, 32'h1C, 32'h60, 32'h64, 32'h68,
            32'h6C, 32'h70, 32'h74, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30,
            32'h34, 32'h38, 32'h3C, 32'h3C, 32'h3C};
    foreach (pcs[i]) pc_q.push_back(pcs[i]);
    push_mem(1'b1, 32'h008, 32'd5);      // sw $1,8($0)
    push_mem(1'b0, 32'h008, 32'd0);      // lw $6,8($0)
    push_mem(1'b1, 32'h118, 32'd1);      // slti -3<-2
    push_mem(1'b1, 32'h11C, 32'd0);      // slti 5<5
    push_mem(1'b1, 32'h100, 32'd2);      // add
    push_mem(1'b1, 32'h104, 32'd8);      // sub
    push_mem(1'b1, 32'h108, 32'd1);      // slt
    push_mem(1'b1, 32'h10C, 32'd5);      // lw result
    push_mem(1'b1, 32'h110, 32'd0);      // $0 after addi $0
    push_mem(1'b1, 32'h114, 32'h0C);     // $31 from jal
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (pc_q.size() > 0) chk("pc", inst_adr, pc_q.pop_front());
      if (mem_read || mem_write) begin
        chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (mem_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_mem: rd=%b wr=%b adr=%h expected no access at %0t",
                   mem_read, mem_write, data_adr, $time);
        end else begin
          mem_ev_t e;
          e = mem_q.pop_front();
          chk("mem_write", {31'd0, mem_write}, {31'd0, e.is_write});
          chk("data_adr", data_adr, e.adr);
          if (e.is_write) chk("data_in", data_in, e.data);
        end
      end
    end
  end

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((pc_q.size() > 0 || mem_q.size() > 0) && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (pc_q.size() == 0 && mem_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d pc and %0d mem expectations left, required 0",
                  pc_q.size(), mem_q.size());
    pc_q.delete();
    mem_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    foreach (imem[i]) imem[i] = 32'd0;
    foreach (dmem[i]) dmem[i] = 32'd0;

    imem[8'h00 >> 2] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);       // addi $1,$0,5
    imem[8'h04 >> 2] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);     // addi $2,$0,-3
    imem[8'h08 >> 2] = enc_j(6'b000011, 32'h40);                   // jal 0x40
    imem[8'h0C >> 2] = enc_i(6'b001000, 5'd0, 5'd7, 16'h0020);     // addi $7,$0,0x20
    imem[8'h10 >> 2] = enc_i(6'b000100, 5'd1, 5'd1, 16'd2);        // beq $1,$1,+2
    imem[8'h14 >> 2] = enc_i(6'b001000, 5'd0, 5'd8, 16'd1);        // skipped
    imem[8'h18 >> 2] = enc_i(6'b001000, 5'd0, 5'd8, 16'd1);        // skipped
    imem[8'h1C >> 2] = enc_j(6'b000010, 32'h60);                   // j 0x60
    imem[8'h20 >> 2] = enc_i(6'b000100, 5'd1, 5'd2, 16'd4);        // beq $1,$2 (not taken)
    imem[8'h24 >> 2] = enc_i(6'b101011, 5'd0, 5'd3, 16'h0100);     // sw $3
    imem[8'h28 >> 2] = enc_i(6'b101011, 5'd0, 5'd4, 16'h0104);     // sw $4
    imem[8'h2C >> 2] = enc_i(6'b101011, 5'd0, 5'd5, 16'h0108);     // sw $5
    imem[8'h30 >> 2] = enc_i(6'b101011, 5'd0, 5'd6, 16'h010C);     // sw $6
    imem[8'h34 >> 2] = enc_i(6'b101011, 5'd0, 5'd0, 16'h0110);     // sw $0
    imem[8'h38 >> 2] = enc_i(6'b101011, 5'd0, 5'd31, 16'h0114);    // sw $31
    imem[8'h3C >> 2] = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFF);     // halt loop
    imem[8'h40 >> 2] = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);         // add $3,$1,$2
    imem[8'h44 >> 2] = enc_r(5'd1, 5'd2, 5'd4, 6'b100010);         // sub $4,$1,$2
    imem[8'h48 >> 2] = enc_r(5'd2, 5'd1, 5'd5, 6'b101010);         // slt $5,$2,$1
    imem[8'h4C >> 2] = enc_i(6'b101011, 5'd0, 5'd1, 16'd8);        // sw $1,8($0)
    imem[8'h50 >> 2] = enc_i(6'b100011, 5'd0, 5'd6, 16'd8);        // lw $6,8($0)
    imem[8'h54 >> 2] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);        // addi $0,$0,7
    imem[8'h58 >> 2] = enc_r(5'd31, 5'd0, 5'd0, 6'b001000);        // jr $31
    imem[8'h60 >> 2] = enc_i(6'b001010, 5'd2, 5'd9, 16'hFFFE);     // slti $9,$2,-2
    imem[8'h64 >> 2] = enc_i(6'b001010, 5'd1, 5'd10, 16'd5);       // slti $10,$1,5
    imem[8'h68 >> 2] = enc_i(6'b111111, 5'd0, 5'd9, 16'd0);        // undefined op
    imem[8'h6C >> 2] = enc_i(6'b101011, 5'd0, 5'd9, 16'h0118);     // sw $9
    imem[8'h70 >> 2] = enc_i(6'b101011, 5'd0, 5'd10, 16'h011C);    // sw $10
    imem[8'h74 >> 2] = enc_r(5'd7, 5'd0, 5'd0, 6'b001000);         // jr $7

    rst = 1'b0;
    #10;
    chk("pc_in_reset", inst_adr, 32'h0);
    push_expected();
    #10 rst = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-program, then full re-run
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("pc_async_reset", inst_adr, 32'h0);
    repeat (2) @(posedge clk);
    push_expected();
    #4 rst = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_single_cycle_core.md
Name: mips_single_cycle_core

Overview:
- Single-cycle 32-bit MIPS processor core: PC, register file, ALU, control unit and next-PC logic.
- Instruction memory and data memory are external combinational-read blocks, wired to the instruction and data ports.
- Every instruction completes in one clock cycle.
- The instruction subset includes jr, so the core supports subroutine call (jal) and return (jr $31).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- inst_adr  output  32  byte address of current instruction (= PC)
- inst  input  32  instruction word from instruction memory (combinational)
- data_adr  output  32  byte address to data memory (= ALU result)
- data_out  input  32  read data returned by data memory
- data_in  output  32  write data to data memory (= rt register value)
- mem_read  output  1  high during lw
- mem_write  output  1  high during sw; the memory writes on the clk rising edge

Interface (already decided):
- One clock.
- Reset is asynchronous and active-low.
- Clock and reset ports are named clk and rst.

Behaviour:

Reset:
- While rst=0: PC=RESET_PC and all 32 registers are cleared to 0, independent of clk.
- Outputs are then combinational from PC=0 and the current inst.
- Reset released mid-program restarts execution at RESET_PC.

Register file:
- 32x32.
- Two combinational read ports (rs, rt).
- One write port, written on the rising edge.
- $0 always reads 0; writes to $0 are discarded.

Instructions (op/funct binary):
- R-type, op 000000, rd <= result:
  - add 100000: rs+rt, wraps mod 2^32, no overflow trap.
  - sub 100010: rs-rt.
  - and 100100: bitwise AND.
  - or 100101: bitwise OR.
  - slt 101010: signed rs<rt gives 1, else 0.
  - jr 001000: PC <= rs; no register write.
- addi 001000: rt <= rs + signext(imm16).
- slti 001010: rt <= (signed rs < signext(imm)) ? 1 : 0.
- lw 100011:
  - data_adr = rs + signext(imm).
  - mem_read=1.
  - rt <= data_out.
- sw 101011:
  - data_adr = rs + signext(imm).
  - data_in = rt.
  - mem_write=1.
- beq 000100: if rs==rt, PC <= PC+4 + (signext(imm)<<2), else PC+4.
- j 000010: PC <= {PC+4[31:28], addr26, 2'b00}.
- jal 000011: $31 <= PC+4; PC <= same target as j.
- Any other op/funct is a no-op: no register write, mem_read=mem_write=0, PC <= PC+4.

Next PC and control outputs:
- Default next PC is PC+4.
- The next PC is selected combinationally, then latched on the rising edge.
- mem_read and mem_write are purely combinational decodes of inst; they are never both high.
- data_adr and data_in are always driven (ALU result and rt value), even when the instruction is not a memory access.
- The data memory treats data_adr as a byte address.
- lw read data is combinational within the cycle and written to rt at the edge.

Jump interaction:
- jal followed later by jr $31 returns to the instruction after the jal.
- jr whose rs equals the register written in the same cycle uses the old (pre-edge) value.

Test Plan:
- Reset: hold rst=0 for 20 ns, then release. Required: inst_adr=0 during reset; first fetch at 0; inst_adr=4 after the first edge.
- Arithmetic:
  - Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1.
  - Required: $3=2, $4=8, $5=1.
  - Writes to $0 leave it at 0.
- Memory:
  - Program sw $1,8($0) with $1=5, then lw $6,8($0).
  - Required during sw: mem_write=1, data_adr=8, data_in=5.
  - Required during lw: mem_read=1 and $6=5.
- Branch: beq $1,$1,+2 at PC=0x10. Required: next PC=0x1C. With unequal operands, next PC=0x14.
- Call/return:
  - jal to 0x40 placed at PC=0x08. Required: $31=0x0C, PC=0x40.
  - Later jr $31. Required: PC=0x0C.
  - Also jr through a non-$31 register holding 0x20. Required: PC=0x20.
- Run 5000 ns with a 16 ns clock period. Required: no X on inst_adr; the program's final stored results match the values above.
